ttl_mux_scan_ctrl: RTL and testbench

Sequencer that time-shares one 8-input multiplexer across all its inputs. It steps the mux Select lines through every channel, waits a programmable settle time, samples the mux Y output into a shadow register, and publishes the assembled parallel word with a one-cycle Valid pulse. It sits between the multiplexer and any logic that needs a periodic parallel snapshot of the mux inputs, either single-shot or free-running.

---
 rtl/ttl_mux_scan_ctrl.sv | 119 +++++++++++
 tb/tb_ttl_mux_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ttl_mux_scan_ctrl.sv
// Time-shares one WIDTH_IN:1 mux: steps Select, settles, samples Y_in and publishes Data with a Valid pulse.
// Optional Changed output is built when TTL_MUX_SCAN_CHANGED_EN is defined.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_IDLE    | no scan; mux disabled, Select parked at 0, waits for Start
//  ST_SETTLE  | mux enabled on channel Select, waiting SETTLE_CYCLES
//  ST_SAMPLE  | one cycle; Y_in captured into shadow[Select] at its closing edge
//  ST_DONE    | one cycle; Data freshly updated, Valid high, mux disabled
module ttl_mux_scan_ctrl #(
   parameter int WIDTH_IN      = 8,
   parameter int WIDTH_SELECT  = $clog2(WIDTH_IN),
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                    Clk,
   input  logic                    Clear_bar,
   input  logic                    Start,
   input  logic                    Continuous,
   input  logic                    Y_in,
   output logic [WIDTH_SELECT-1:0] Select,
   output logic                    Enable_bar,
   output logic [WIDTH_IN-1:0]     Data,
   output logic                    Valid,
`ifdef TTL_MUX_SCAN_CHANGED_EN
   output logic                    Changed,
`endif
   output logic                    Busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [WIDTH_SELECT-1:0] SEL_LAST = WIDTH_SELECT'(WIDTH_IN - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [WIDTH_SELECT-1:0] sel_q, sel_d;
   logic [WIDTH_IN-1:0]     shadow_q, shadow_d;
   logic [WIDTH_IN-1:0]     data_q, data_d;

   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sel_q    <= '0;
         shadow_q <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      unique case (state_q)
         ST_IDLE: begin
            sel_d = '0;
            cnt_d = '0;
            if (Start) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_SAMPLE: begin
            shadow_d[sel_q] = Y_in;
            cnt_d           = '0;
            // Last channel publishes shadow including the bit captured this cycle.
            if (sel_q == SEL_LAST) begin
               data_d  = shadow_d;
               state_d = ST_DONE;
            end else begin
               sel_d   = sel_q + WIDTH_SELECT'(1);
               state_d = ST_SETTLE;
            end
         end
         ST_DONE: begin
            sel_d   = '0;
            cnt_d   = '0;
            state_d = Continuous ? ST_SETTLE : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign Select     = sel_q;
   assign Enable_bar = !((state_q == ST_SETTLE) || (state_q == ST_SAMPLE));
   assign Valid      = (state_q == ST_DONE);
   assign Busy       = (state_q != ST_IDLE);
   assign Data       = data_q;

`ifdef TTL_MUX_SCAN_CHANGED_EN
   logic changed_q;

   // Difference is latched on the same edge Data updates, so it lines up with Valid.
   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar)
         changed_q <= 1'b0;
      else if ((state_q == ST_SAMPLE) && (sel_q == SEL_LAST))
         changed_q <= (data_d != data_q);
   end

   assign Changed = changed_q && Valid;
`endif

endmodule

// File: tb/tb_ttl_mux_scan_ctrl.sv
// Bench for ttl_mux_scan_ctrl: two instances (SETTLE_CYCLES 1 and 3) against a scan-position model.
`timescale 1ns/1ps
module tb_ttl_mux_scan_ctrl;
   localparam int N  = 8;
   localparam int S0 = 1;
   localparam int S1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] clr   = 2'b00;
   logic [1:0] start = 2'b00;
   logic [1:0] cont  = 2'b00;
   logic [1:0] y, en_b, valid, busy, chg;
   logic [2:0] sel  [2];
   logic [7:0] data [2];
   logic [7:0] d    [2] = '{8'h00, 8'h00};

   int n_cmp = 0;
   int n_bad = 0;
   int e;

   // Mux behaviour: output forced low while disabled.
   assign y[0] = en_b[0] ? 1'b0 : d[0][sel[0]];
   assign y[1] = en_b[1] ? 1'b0 : d[1][sel[1]];

   ttl_mux_scan_ctrl #(.WIDTH_IN(N), .SETTLE_CYCLES(S0)) dut0 (
      .Clk(clk), .Clear_bar(clr[0]), .Start(start[0]), .Continuous(cont[0]), .Y_in(y[0]),
      .Select(sel[0]), .Enable_bar(en_b[0]), .Data(data[0]), .Valid(valid[0]),
`ifdef TTL_MUX_SCAN_CHANGED_EN
      .Changed(chg[0]),
`endif
      .Busy(busy[0]));

   ttl_mux_scan_ctrl #(.WIDTH_IN(N), .SETTLE_CYCLES(S1)) dut1 (
      .Clk(clk), .Clear_bar(clr[1]), .Start(start[1]), .Continuous(cont[1]), .Y_in(y[1]),
      .Select(sel[1]), .Enable_bar(en_b[1]), .Data(data[1]), .Valid(valid[1]),
`ifdef TTL_MUX_SCAN_CHANGED_EN
      .Changed(chg[1]),
`endif
      .Busy(busy[1]));

`ifndef TTL_MUX_SCAN_CHANGED_EN
   assign chg = 2'b00;
`endif

   // Model: m_pos = -1 idle, 0..len-1 position inside a scan, len = the Valid cycle.
   int         m_pos  [2] = '{-1, -1};
   logic [7:0] m_acc  [2] = '{8'h00, 8'h00};
   logic [7:0] m_data [2] = '{8'h00, 8'h00};
   logic       m_chg  [2] = '{1'b0, 1'b0};

   function automatic int per_of(input int i);
      return ((i == 0) ? S0 : S1) + 1;
   endfunction

   task automatic model_reset(input int i);
      m_pos[i]  = -1;
      m_acc[i]  = 8'h00;
      m_data[i] = 8'h00;
      m_chg[i]  = 1'b0;
   endtask

   task automatic model_edge(input int i);
      int per, len, ch;
      per = per_of(i);
      len = N * per;
      if (m_pos[i] < 0) begin
         if (start[i]) m_pos[i] = 0;
      end else if (m_pos[i] < len) begin
         ch = m_pos[i] / per;
         if (m_pos[i] % per == per - 1) m_acc[i][ch] = d[i][ch];
         if (m_pos[i] == len - 1) begin
            m_chg[i]  = (m_acc[i] != m_data[i]);
            m_data[i] = m_acc[i];
         end
         m_pos[i] = m_pos[i] + 1;
      end else begin
         m_pos[i] = cont[i] ? 0 : -1;
      end
   endtask

   always @(posedge clk or negedge clr[0]) if (!clr[0]) model_reset(0); else model_edge(0);
   always @(posedge clk or negedge clr[1]) if (!clr[1]) model_reset(1); else model_edge(1);

   task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d t=%0t actual=%0h required=%0h", name, i, $time, act, exp);
      end
   endtask

   task automatic compare_one(input int i);
      int per, len, exp_sel;
      bit scanning, done;
      per      = per_of(i);
      len      = N * per;
      scanning = (m_pos[i] >= 0) && (m_pos[i] < len);
      done     = (m_pos[i] == len);
      exp_sel  = scanning ? m_pos[i] / per : (done ? N - 1 : 0);
      check("select", i, 32'(sel[i]), exp_sel);
      check("enable_bar", i, 32'(en_b[i]), 32'(!scanning));
      check("valid", i, 32'(valid[i]), 32'(done));
      check("busy", i, 32'(busy[i]), 32'(m_pos[i] >= 0));
      check("data", i, 32'(data[i]), 32'(m_data[i]));
`ifdef TTL_MUX_SCAN_CHANGED_EN
      check("changed", i, 32'(chg[i]), 32'(done && m_chg[i]));
`endif
   endtask

   always @(negedge clk) for (int i = 0; i < 2; i++) compare_one(i);

   task automatic wait_valid(input int i, input int limit, input bit drop_start, output int edges);
      edges = 0;
      do begin
         @(negedge clk);
         edges++;
         if (drop_start) start[i] = 1'b0;
      end while (!valid[i] && edges < limit);
      check("valid_seen", i, 32'(valid[i]), 32'd1);
   endtask

   task automatic check_reset_vals(input int i);
      check("rst_select", i, 32'(sel[i]), 32'd0);
      check("rst_enable_bar", i, 32'(en_b[i]), 32'd1);
      check("rst_data", i, 32'(data[i]), 32'd0);
      check("rst_valid", i, 32'(valid[i]), 32'd0);
      check("rst_busy", i, 32'(busy[i]), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      #3 clr = 2'b11;

      // Reset asserted between edges, partway into a scan.
      @(negedge clk);
      d[0] = 8'hFF;
      start[0] = 1'b1;
      repeat (5) @(negedge clk) start[0] = 1'b0;
      #3 clr[0] = 1'b0;
      #1 check_reset_vals(0);
      @(negedge clk);
      #3 clr[0] = 1'b1;

      // Single-shot, SETTLE_CYCLES=1.
      @(negedge clk);
      d[0] = 8'hA5;
      start[0] = 1'b1;
      wait_valid(0, 40, 1'b1, e);
      check("ss_latency", 0, e, 32'd17);
      check("ss_data", 0, 32'(data[0]), 32'hA5);
      @(negedge clk);
      check("ss_busy_low", 0, 32'(busy[0]), 32'd0);

      // SETTLE_CYCLES=3 with Start held through the scan.
      d[1] = 8'h3C;
      start[1] = 1'b1;
      wait_valid(1, 80, 1'b0, e);
      check("s3_latency", 1, e, 32'd33);
      check("s3_data", 1, 32'(data[1]), 32'h3C);
      @(negedge clk);
      check("s3_idle_gap", 1, 32'(busy[1]), 32'd0);
      @(negedge clk);
      check("s3_restart", 1, 32'(busy[1]), 32'd1);
      d[1] = 8'hC3;
      wait_valid(1, 80, 1'b1, e);
      check("s3_latency2", 1, e, 32'd32);
      check("s3_data2", 1, 32'(data[1]), 32'hC3);

      // Continuous mode, input word changes partway through the first scan.
      @(negedge clk);
      d[0] = 8'h0F;
      cont[0] = 1'b1;
      start[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      repeat (7) @(negedge clk);
      d[0] = 8'hF0;
      wait_valid(0, 40, 1'b0, e);
      check("cont_rest1", 0, e, 32'd9);
      check("cont_data1", 0, 32'(data[0]), 32'hF7);
      wait_valid(0, 40, 1'b0, e);
      check("cont_period2", 0, e, 32'd17);
      check("cont_data2", 0, 32'(data[0]), 32'hF0);
`ifdef TTL_MUX_SCAN_CHANGED_EN
      check("cont_changed2", 0, 32'(chg[0]), 32'd1);
`endif
      wait_valid(0, 40, 1'b0, e);
      check("cont_period3", 0, e, 32'd17);
      check("cont_data3", 0, 32'(data[0]), 32'hF0);
`ifdef TTL_MUX_SCAN_CHANGED_EN
      check("cont_changed3", 0, 32'(chg[0]), 32'd0);
`endif
      cont[0] = 1'b0;
      @(negedge clk);
      check("cont_stop", 0, 32'(busy[0]), 32'd0);

      // Reset during SAMPLE of channel 4, then a clean scan.
      d[0] = 8'h5A;
      start[0] = 1'b1;
      repeat (10) @(negedge clk) start[0] = 1'b0;
      check("ch4_select", 0, 32'(sel[0]), 32'd4);
      check("ch4_enable_bar", 0, 32'(en_b[0]), 32'd0);
      #3 clr[0] = 1'b0;
      #1 check_reset_vals(0);
      repeat (3) @(negedge clk);
      #3 clr[0] = 1'b1;
      @(negedge clk);
      d[0] = 8'h96;
      start[0] = 1'b1;
      wait_valid(0, 40, 1'b1, e);
      check("post_rst_latency", 0, e, 32'd17);
      check("post_rst_data", 0, 32'(data[0]), 32'h96);

      // Randomized traffic on both instances; the per-cycle compare does the checking.
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            start[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) cont[i] = 1'($urandom_range(0, 1));
            d[i] = 8'($urandom);
            if ($urandom_range(0, 149) == 0) begin
               #3 clr[i] = 1'b0;
               @(negedge clk);
               #3 clr[i] = 1'b1;
            end
         end
      end

      cont  = 2'b00;
      start = 2'b00;
      repeat (40) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
